sm_hex_entry: RTL and testbench
===============================

SM_HEX_ENTRY -- requirements
Module: sm_hex_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable clk cycles before a key level is accepted.
REQ-002 Parameter DATA_WIDTH, default 32, width of the assembled word; a multiple of 4.
REQ-003 Parameter ADDR_WIDTH, default 5, width of the target register address.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_digit_n  input  1  raw active-low push button, asynchronous to clk; a press appends one nibble.
REQ-007 key_commit_n  input  1  raw active-low push button, asynchronous to clk; a press issues a write.
REQ-008 nibble  input  4  hex digit from switches, sampled on an accepted digit press.
REQ-009 addr_in  input  ADDR_WIDTH  target address from switches, sampled on an accepted commit press.
REQ-010 shadow  output  DATA_WIDTH  word being assembled, driven to the hex display.
REQ-011 digit_count  output  4  nibbles entered since last clear, 0..DATA_WIDTH/4.
REQ-012 wr_valid  output  1  write request pending.
REQ-013 wr_ready  input  1  sink accepts the write in any cycle where wr_valid and wr_ready are both high.
REQ-014 wr_addr  output  ADDR_WIDTH  write address, stable while wr_valid is high.
REQ-015 wr_data  output  DATA_WIDTH  write data, stable while wr_valid is high.
REQ-016 busy  output  1  high when the FSM is in WRITE.

Function
REQ-017 Each key input SHALL pass a 2-flop synchronizer, then a debouncer that updates its accepted level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; a glitch restarts the count.
REQ-018 A press pulse SHALL be asserted for exactly one cycle on the accepted level's 1->0 transition; release produces no pulse.
REQ-019 Latency from a stable raw edge to its press pulse SHALL be 2 + DEBOUNCE_CYCLES cycles, +/-1.
REQ-020 FSM states: IDLE, WRITE.
REQ-021 In IDLE, digit pulse: shadow <= {shadow[DATA_WIDTH-5:0], nibble}; digit_count increments and saturates at DATA_WIDTH/4, while shifting continues (oldest nibble discarded).
REQ-022 In IDLE, commit pulse: wr_addr <= addr_in, wr_data <= shadow, wr_valid <= 1, next state WRITE; this is allowed with digit_count = 0.
REQ-023 If digit and commit pulses coincide in IDLE, commit SHALL win and the digit SHALL be dropped.
REQ-024 In WRITE, wr_valid, wr_addr and wr_data SHALL hold until the handshake cycle; all press pulses are ignored.
REQ-025 On handshake: wr_valid <= 0, shadow <= 0, digit_count <= 0, next state IDLE; the next write can issue 1 cycle later at the earliest.
REQ-026 wr_ready while wr_valid is low SHALL have no effect.
REQ-027 busy SHALL equal (state == WRITE) and coincide with wr_valid.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, shadow 0, digit_count 0, wr_valid 0, wr_addr 0, wr_data 0, and debouncer accepted levels to 1 (released) with counters cleared.
REQ-029 Reset during WRITE SHALL drop the pending write without handshake.
REQ-030 A key held down through reset release SHALL NOT produce a press pulse until it has been released and pressed again.

Structure
REQ-031 The FSM state encoding and the default widths SHALL live in the shared sm_ package/include file.
REQ-032 Synchronizer, debouncer and edge detector SHALL be one sub-module, sm_debounce, instantiated once per key.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Digit presses with nibble 0x1..0x8 -> shadow 0x12345678, digit_count 8; a ninth press with 0x9 -> shadow 0x23456789, digit_count 8.
REQ-034 Commit with addr_in 5'h0A, wr_ready held low 10 cycles -> wr_valid, wr_addr 0x0A and wr_data 0x23456789 stable for 10 cycles; wr_ready high -> wr_valid 0, shadow 0 next cycle.
REQ-035 A 2-cycle low glitch on key_digit_n -> no pulse, shadow unchanged; a 3-cycle bounce then steady low -> exactly one digit append.
REQ-036 Digit and commit edges applied simultaneously in IDLE -> one write of the prior shadow value, nibble not appended.
REQ-037 Digit press during WRITE -> shadow unchanged; rst_n asserted during WRITE -> wr_valid 0 in the same cycle, all outputs 0.

Source files
------------

// File: rtl/sm_hex_entry_pkg.sv
// Shared definitions for the hex-entry block: FSM encoding, default widths
// and the saturating digit counter helper.
package sm_hex_entry_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH      = 5;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v == lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sm_hex_entry_debounce.sv
// Key conditioner: 2-flop synchronizer, level debouncer and press detector
// producing a one-cycle pulse on each accepted press.
module sm_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Sync flops reset to "pressed" and armed starts low, so a key held through
  // reset must be seen released before any press can be reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b1;
      armed   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // Stage p0 -> p1: synchronizer
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 && level) armed <= 1'b1;
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
          press <= armed & ~sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sm_hex_entry.sv
// Hex word entry from push buttons and switches; committed words are issued
// as a valid/ready write request.
module sm_hex_entry
  import sm_hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_digit_n,
  input  logic                  key_commit_n,
  input  logic [3:0]            nibble,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] shadow,
  output logic [3:0]            digit_count,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  localparam logic [3:0] MAX_DIGITS = 4'(DATA_WIDTH / 4);

  logic   digit_press;
  logic   commit_press;
  state_t state;

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_digit_n),
    .press (digit_press)
  );

  sm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_commit_n),
    .press (commit_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shadow      <= '0;
      digit_count <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Commit has priority; a coincident digit press is dropped.
          if (commit_press) begin
            wr_addr  <= addr_in;
            wr_data  <= shadow;
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= WRITE;
          end else if (digit_press) begin
            shadow      <= {shadow[DATA_WIDTH-5:0], nibble};
            digit_count <= sat_inc(digit_count, MAX_DIGITS);
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_valid    <= 1'b0;
            busy        <= 1'b0;
            shadow      <= '0;
            digit_count <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_hex_entry.sv
// Directed bench for sm_hex_entry with a short debounce window.
module tb_sm_hex_entry;

  localparam int DB = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_digit_n;
  logic          key_commit_n;
  logic [3:0]    nibble;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] shadow;
  logic [3:0]    digit_count;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  sm_hex_entry #(.DEBOUNCE_CYCLES(DB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_digit_n  (key_digit_n),
    .key_commit_n (key_commit_n),
    .nibble       (nibble),
    .addr_in      (addr_in),
    .shadow       (shadow),
    .digit_count  (digit_count),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, leaving time 1 unit after the last rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_digit(input logic [3:0] nb);
    nibble = nb;
    key_digit_n = 1'b0;
    tick(12);
    key_digit_n = 1'b1;
    tick(12);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && wr_valid !== 1'b1; i++) tick(1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_shadow"}, 64'(shadow), 64'h0);
    check({tag, "_count"},  64'(digit_count), 64'h0);
    check({tag, "_valid"},  64'(wr_valid), 64'h0);
    check({tag, "_addr"},   64'(wr_addr), 64'h0);
    check({tag, "_data"},   64'(wr_data), 64'h0);
    check({tag, "_busy"},   64'(busy), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_digit_n = 1'b0;
    key_commit_n = 1'b1;
    nibble = 4'h0;
    addr_in = '0;
    wr_ready = 1'b0;
    #23;
    check_idle_zero("reset");

    // Digit key held through reset release must not append.
    @(posedge clk); #1;
    rst_n = 1'b1;
    nibble = 4'hC;
    tick(20);
    check("held_shadow", 64'(shadow), 64'h0);
    check("held_count", 64'(digit_count), 64'h0);
    key_digit_n = 1'b1;
    tick(20);
    check("held_release_shadow", 64'(shadow), 64'h0);

    press_digit(4'h1);
    check("first_shadow", 64'(shadow), 64'h1);
    check("first_count", 64'(digit_count), 64'h1);
    for (int d = 2; d <= 8; d++) press_digit(4'(d));
    check("eight_shadow", 64'(shadow), 64'h12345678);
    check("eight_count", 64'(digit_count), 64'h8);
    press_digit(4'h9);
    check("nine_shadow", 64'(shadow), 64'h23456789);
    check("nine_count", 64'(digit_count), 64'h8);

    // Two-cycle glitch is shorter than the debounce window.
    nibble = 4'hE;
    key_digit_n = 1'b0;
    tick(2);
    key_digit_n = 1'b1;
    tick(15);
    check("glitch_shadow", 64'(shadow), 64'h23456789);

    // Commit with sink stalled.
    addr_in = 5'h0A;
    key_commit_n = 1'b0;
    wait_valid();
    check("commit_valid", 64'(wr_valid), 64'h1);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(wr_valid), 64'h1);
      check("stall_busy", 64'(busy), 64'h1);
      check("stall_addr", 64'(wr_addr), 64'h0A);
      check("stall_data", 64'(wr_data), 64'h23456789);
      addr_in = 5'(i);
      tick(1);
    end
    key_commit_n = 1'b1;
    press_digit(4'hF);
    check("write_digit_shadow", 64'(shadow), 64'h23456789);
    check("write_digit_valid", 64'(wr_valid), 64'h1);
    check("write_digit_data", 64'(wr_data), 64'h23456789);
    wr_ready = 1'b1;
    tick(1);
    wr_ready = 1'b0;
    check("hs_valid", 64'(wr_valid), 64'h0);
    check("hs_busy", 64'(busy), 64'h0);
    check("hs_shadow", 64'(shadow), 64'h0);
    check("hs_count", 64'(digit_count), 64'h0);

    // Ready with nothing pending is ignored.
    wr_ready = 1'b1;
    tick(3);
    wr_ready = 1'b0;
    check("idle_ready_valid", 64'(wr_valid), 64'h0);
    check("idle_ready_busy", 64'(busy), 64'h0);

    // Bounce: three short lows, then steady low -> one append.
    nibble = 4'hA;
    for (int b = 0; b < 3; b++) begin
      key_digit_n = 1'b0;
      tick(3);
      key_digit_n = 1'b1;
      tick(1);
    end
    key_digit_n = 1'b0;
    tick(15);
    key_digit_n = 1'b1;
    tick(15);
    check("bounce_shadow", 64'(shadow), 64'hA);
    check("bounce_count", 64'(digit_count), 64'h1);

    // Simultaneous digit and commit: commit wins, nibble dropped.
    nibble = 4'hB;
    addr_in = 5'h11;
    key_digit_n = 1'b0;
    key_commit_n = 1'b0;
    wait_valid();
    check("both_valid", 64'(wr_valid), 64'h1);
    check("both_addr", 64'(wr_addr), 64'h11);
    check("both_data", 64'(wr_data), 64'hA);
    check("both_shadow", 64'(shadow), 64'hA);
    check("both_count", 64'(digit_count), 64'h1);
    key_digit_n = 1'b1;
    key_commit_n = 1'b1;
    tick(15);
    wr_ready = 1'b1;
    tick(1);
    wr_ready = 1'b0;
    check("both_hs_valid", 64'(wr_valid), 64'h0);

    // Reset while a write is pending drops it immediately.
    press_digit(4'h3);
    check("pre_rst_shadow", 64'(shadow), 64'h3);
    addr_in = 5'h07;
    key_commit_n = 1'b0;
    wait_valid();
    check("pre_rst_valid", 64'(wr_valid), 64'h1);
    check("pre_rst_data", 64'(wr_data), 64'h3);
    key_commit_n = 1'b1;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("wr_reset");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check_idle_zero("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
